simon_game_core: RTL and testbench
==================================

# simon_game_core

Parametrised Simon Says game engine: the generalised successor of the fixed four-colour top-level game logic. It folds start, sequence generation, playback, input capture and checking into one FSM, and parameterises colour count, maximum sequence length, playback timing and the input timeout. It sits between the board pads (buttons, LEDs, start, seed) and any debug/score logic that reads `state` and `round`.

## Interface
- `N_COLOURS`, 4: number of colour channels, 2..8; `CW = $clog2(N_COLOURS)`.
- `MAX_LEN`, 16: maximum sequence length, 2..32; `LW = $clog2(MAX_LEN+1)`.
- `SHOW_CYCLES`, 4: cycles each colour is lit during playback, ≥1.
- `GAP_CYCLES`, 2: dark cycles after each played colour, ≥1.
- `TIMEOUT_CYCLES`, 64: maximum cycles between entering INPUT or a valid press and the next press, ≥2.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; its rising edge starts a game.
- `seed` in 8: LFSR seed, sampled in IDLE on the start edge.
- `btn` in N_COLOURS: player buttons, active high, synchronous to `clk`.
- `led` out N_COLOURS: one-hot colour lamps.
- `state` out 3: IDLE=0, GEN=1, SHOW=2, INPUT=3, WIN=4, LOSE=5.
- `round` out LW: current sequence length under play.
- `win` out 1: high in WIN.
- `lose` out 1: high in LOSE.

## Operation
- Reset: state IDLE, `led`=0, `round`=0, `win`=`lose`=0, `start_q`=0, `btn_q`=0, LFSR=8'h01, all counters 0.
- LFSR: 8-bit Fibonacci, `q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}`; a zero seed is loaded as 8'h01.
- `start_edge = start & ~start_q`; `press = btn & ~btn_q`. `start_q`/`btn_q` update every cycle in every state.
- IDLE: on `start_edge`, load seed → GEN.
- GEN: MAX_LEN cycles; each cycle advance the LFSR and write `seq[i] = next_q % N_COLOURS` (low CW bits, then mod). On the last write: `round`=1 → SHOW.
- SHOW: for i = 0..round-1: `led = 1<<seq[i]` for SHOW_CYCLES, then `led`=0 for GAP_CYCLES. After the final gap: index=0, timeout counter cleared → INPUT.
- INPUT, per cycle: `press`=0: timeout counter +1; on reaching TIMEOUT_CYCLES → LOSE. Exactly one bit set and equal to `seq[index]`: valid; index+1, timeout cleared. If index+1 == round: `round`==MAX_LEN → WIN, else `round`+1 → SHOW. Wrong bit or more than one bit set → LOSE.
- WIN/LOSE: hold `win`/`lose` and `led`=0. On `start_edge` → GEN without reseeding; the LFSR continues. `round` keeps its value until GEN completes.
- `start_edge` is ignored in GEN, SHOW and INPUT.

## Timing
- `start` rises at edge k; `state`=GEN from edge k+1. GEN holds MAX_LEN cycles; the first SHOW lamp lights the cycle after GEN ends.
- Round r playback lasts r·(SHOW_CYCLES+GAP_CYCLES) cycles.
- A press is seen the cycle after `btn` is registered high. The transition to SHOW/WIN/LOSE is visible on the following edge.
- A button held from SHOW into INPUT never counts; it must be released and re-pressed.
- A valid press in the cycle the timeout would expire wins over the timeout.
- `rst_n` low mid-game returns all outputs to reset values immediately; no state survives.

## Configuration
- `SIMON_ECHO_EN` defined: in INPUT, `led` = `btn_q & ~(btn_q-1)` (lowest held button lit) for player feedback.
- Not defined: `led`=0 throughout INPUT.
- All other behaviour is identical.

## Test plan
Common setup: N_COLOURS=4, MAX_LEN=4, SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=16, seed 8'h01. Expected sequence: 2,0,0,1.

- Reset/start: release `rst_n`, pulse `start` → outputs at reset values; `state`=1 for 4 cycles, then `led`=4'b0100 for 4 cycles, then 0 for 2, then `state`=3, `round`=1.
- Full win: answer each round correctly (btn 4'b0100, 4'b0001, 4'b0001, 4'b0010 one-hot pulses) → `round` steps 1..4, then `state`=4, `win`=1.
- Wrong colour: round 1, press 4'b0001 → `state`=5, `lose`=1 the cycle after the press is registered.
- Multi-press and held button: hold 4'b0100 across SHOW → no advance. Press 4'b0101 in INPUT → LOSE.
- Timeout: no press in INPUT → LOSE exactly 16 cycles after entry. A press at cycle 16 → advance instead.
- Async reset during SHOW (`rst_n` low mid-lamp) → `led`=0, `state`=0, `round`=0 immediately. Restart with seed 8'h00 → behaves as seed 8'h01.

Source files
------------

// File: rtl/simon_game_core.sv
// simon_game_core
// Parametrised Simon Says engine. One FSM covers start detection, sequence
// generation from an 8-bit LFSR, lamp playback, player input capture and
// answer checking.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : level input, its rising edge starts a game
//   seed   : LFSR seed, sampled in IDLE on the start edge (zero loads 8'h01)
//   btn    : player buttons, active high, synchronous to clk
//   led    : one-hot colour lamps
//   state  : IDLE=0 GEN=1 SHOW=2 INPUT=3 WIN=4 LOSE=5
//   round  : sequence length currently under play
//   win    : high while in WIN
//   lose   : high while in LOSE
//
// Build option
//   SIMON_ECHO_EN : when defined, the lowest held button is echoed on led
//                   while the player is entering the sequence. When not
//                   defined, led stays dark throughout INPUT.
module simon_game_core #(
    parameter int N_COLOURS      = 4,
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CW = $clog2(N_COLOURS),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           seed,
    input  logic [N_COLOURS-1:0] btn,
    output logic [N_COLOURS-1:0] led,
    output logic [2:0]           state,
    output logic [LW-1:0]        round,
    output logic                 win,
    output logic                 lose
);

    localparam int SLOT = SHOW_CYCLES + GAP_CYCLES;
    localparam int PW   = $clog2(SLOT + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [N_COLOURS-1:0] ONE = {{(N_COLOURS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        SHOW  = 3'd2,
        INPUT = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

    state_t               fsm;
    logic                 start_q;
    logic [N_COLOURS-1:0] btn_q;
    logic [7:0]           lfsr;
    logic [LW-1:0]        idx;
    logic [PW-1:0]        pcnt;
    logic [TW-1:0]        tcnt;

    // Sized to the full index range so any idx value addresses a real entry.
    logic [CW-1:0]        seq [0:(1<<LW)-1];

    logic [7:0]           lfsr_next;
    logic [CW-1:0]        gen_colour;
    logic                 start_edge;
    logic [N_COLOURS-1:0] press;
    logic                 press_one;
    logic                 press_hit;
    logic [LW-1:0]        idx_inc;
    logic [N_COLOURS-1:0] echo_led;

    // Next LFSR value, and the colour it produces (low bits folded into range
    // so non-power-of-two colour counts still land on a valid lamp).
    assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign gen_colour = CW'(32'(lfsr_next[CW-1:0]) % 32'(N_COLOURS));

    // Edge detection against the registered copies; a button already held
    // when INPUT begins never produces a press.
    assign start_edge = start & ~start_q;
    assign press      = btn & ~btn_q;
    assign press_one  = (press != '0) && ((press & (press - ONE)) == '0);
    assign press_hit  = (press == (ONE << seq[idx]));
    assign idx_inc    = idx + LW'(1);

`ifdef SIMON_ECHO_EN
    // btn is the value btn_q takes at this edge, so the registered lamp shows
    // the lowest bit of the held-button register.
    assign echo_led = btn & ~(btn - ONE);
`else
    assign echo_led = '0;
`endif

    assign state = fsm;

    // Sequence memory. Only written during GEN, one entry per cycle, so it
    // needs no reset: every entry read later has been written first.
    always_ff @(posedge clk) begin
        if (fsm == GEN) begin
            seq[idx] <= gen_colour;
        end
    end

    // Main game FSM. All outputs are registered here; every transition into
    // SHOW preloads the first lamp so it lights in the first SHOW cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            led     <= '0;
            round   <= '0;
            win     <= 1'b0;
            lose    <= 1'b0;
            start_q <= 1'b0;
            btn_q   <= '0;
            lfsr    <= 8'h01;
            idx     <= '0;
            pcnt    <= '0;
            tcnt    <= '0;
        end else begin
            start_q <= start;
            btn_q   <= btn;
            case (fsm)
                IDLE: begin
                    if (start_edge) begin
                        lfsr <= (seed == 8'h00) ? 8'h01 : seed;
                        idx  <= '0;
                        fsm  <= GEN;
                    end
                end
                GEN: begin
                    lfsr <= lfsr_next;
                    if (idx == LW'(MAX_LEN - 1)) begin
                        idx   <= '0;
                        pcnt  <= '0;
                        round <= LW'(1);
                        led   <= ONE << seq[0];
                        fsm   <= SHOW;
                    end else begin
                        idx <= idx_inc;
                    end
                end
                SHOW: begin
                    if (pcnt == PW'(SLOT - 1)) begin
                        pcnt <= '0;
                        if (idx_inc == round) begin
                            idx  <= '0;
                            tcnt <= '0;
                            led  <= echo_led;
                            fsm  <= INPUT;
                        end else begin
                            idx <= idx_inc;
                            led <= ONE << seq[idx_inc];
                        end
                    end else begin
                        pcnt <= pcnt + PW'(1);
                        if (pcnt == PW'(SHOW_CYCLES - 1)) begin
                            led <= '0;
                        end
                    end
                end
                INPUT: begin
                    led <= echo_led;
                    if (press == '0) begin
                        if (tcnt + TW'(1) == TW'(TIMEOUT_CYCLES)) begin
                            lose <= 1'b1;
                            led  <= '0;
                            fsm  <= LOSE;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end else if (press_one && press_hit) begin
                        tcnt <= '0;
                        if (idx_inc == round) begin
                            idx <= '0;
                            if (round == LW'(MAX_LEN)) begin
                                win <= 1'b1;
                                led <= '0;
                                fsm <= WIN;
                            end else begin
                                round <= round + LW'(1);
                                pcnt  <= '0;
                                led   <= ONE << seq[0];
                                fsm   <= SHOW;
                            end
                        end else begin
                            idx <= idx_inc;
                        end
                    end else begin
                        lose <= 1'b1;
                        led  <= '0;
                        fsm  <= LOSE;
                    end
                end
                WIN, LOSE: begin
                    led <= '0;
                    if (start_edge) begin
                        win  <= 1'b0;
                        lose <= 1'b0;
                        idx  <= '0;
                        fsm  <= GEN;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_game_core.sv
// tb_simon_game_core
// Directed bench for simon_game_core (4 colours, length 4, 4 lit / 2 dark,
// timeout 16). A behavioural game model runs alongside the DUT and a compare
// process checks every output on each falling edge; hand-computed literals
// pin the key timings and the expected colour sequence.
`timescale 1ns/1ps
module tb_simon_game_core;

    localparam int NC   = 4;
    localparam int ML   = 4;
    localparam int SC   = 4;
    localparam int GC   = 2;
    localparam int TC   = 16;
    localparam int SLOT = SC + GC;
    localparam int LWT  = $clog2(ML + 1);

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [7:0]     seed  = 8'h01;
    logic [NC-1:0]  btn   = '0;
    logic [NC-1:0]  led;
    logic [2:0]     state;
    logic [LWT-1:0] round;
    logic           win;
    logic           lose;

    int compared   = 0;
    int mismatched = 0;

    int m_mode;
    int m_round;
    int m_show_t;
    int m_gen_n;
    int m_pos;
    int m_idle;
    logic [7:0]    m_lfsr;
    int            m_seq [ML];
    logic          m_start_prev;
    logic [NC-1:0] m_btn_prev;

    int            exp_seq [ML] = '{2, 0, 0, 1};
    logic [NC-1:0] presses [ML] = '{4'b0100, 4'b0001, 4'b0001, 4'b0010};

    simon_game_core #(
        .N_COLOURS(NC),
        .MAX_LEN(ML),
        .SHOW_CYCLES(SC),
        .GAP_CYCLES(GC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .seed(seed),
        .btn(btn),
        .led(led),
        .state(state),
        .round(round),
        .win(win),
        .lose(lose)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Records one comparison and reports it when it does not hold.
    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives the inputs just after a rising edge and lets n edges pass.
    task automatic applyStimulus(input logic s, input logic [NC-1:0] b, input int n);
        start = s;
        btn   = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits a bounded number of cycles for the DUT to report a state.
    task automatic waitState(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (int'(state) != target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, int'(state), target);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // Expected lamp: playback time splits into fixed slots of lit then dark.
    function automatic logic [NC-1:0] exp_led();
        if (m_mode == 2 && (m_show_t % SLOT) < SC) begin
            return NC'(1 << m_seq[m_show_t / SLOT]);
        end
        return '0;
    endfunction

    task automatic model_reset();
        m_mode       = 0;
        m_round      = 0;
        m_show_t     = 0;
        m_gen_n      = 0;
        m_pos        = 0;
        m_idle       = 0;
        m_lfsr       = 8'h01;
        m_start_prev = 1'b0;
        m_btn_prev   = '0;
    endtask

    // Game rules: the model tracks elapsed playback time, answer position and
    // idle time rather than any per-lamp counters.
    task automatic model_step();
        logic          se;
        logic [NC-1:0] pr;
        se = start && !m_start_prev;
        pr = btn & ~m_btn_prev;
        case (m_mode)
            0: if (se) begin
                m_lfsr  = (seed == 8'h00) ? 8'h01 : seed;
                m_gen_n = 0;
                m_mode  = 1;
            end
            1: begin
                m_lfsr = lfsr_step(m_lfsr);
                m_seq[m_gen_n] = int'(m_lfsr[1:0]) % NC;
                m_gen_n++;
                if (m_gen_n == ML) begin
                    m_round  = 1;
                    m_show_t = 0;
                    m_mode   = 2;
                end
            end
            2: begin
                m_show_t++;
                if (m_show_t == m_round * SLOT) begin
                    m_mode = 3;
                    m_pos  = 0;
                    m_idle = 0;
                end
            end
            3: begin
                if (pr == '0) begin
                    m_idle++;
                    if (m_idle == TC) m_mode = 5;
                end else if ($countones(pr) == 1 && pr == NC'(1 << m_seq[m_pos])) begin
                    m_pos++;
                    m_idle = 0;
                    if (m_pos == m_round) begin
                        if (m_round == ML) begin
                            m_mode = 4;
                        end else begin
                            m_round++;
                            m_show_t = 0;
                            m_mode   = 2;
                        end
                    end
                end else begin
                    m_mode = 5;
                end
            end
            4, 5: if (se) begin
                m_gen_n = 0;
                m_mode  = 1;
            end
            default: ;
        endcase
        m_start_prev = start;
        m_btn_prev   = btn;
    endtask

    // Model advances on every rising edge using the inputs the DUT samples.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison on the falling edge; under reset the outputs
    // must already sit at their reset values.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("cmp_reset_state", int'(state), 0);
                checkOutput("cmp_reset_led", int'(led), 0);
                checkOutput("cmp_reset_round", int'(round), 0);
                checkOutput("cmp_reset_win", int'(win), 0);
                checkOutput("cmp_reset_lose", int'(lose), 0);
            end else begin
                checkOutput("cmp_state", int'(state), m_mode);
                checkOutput("cmp_led", int'(led), int'(exp_led()));
                checkOutput("cmp_round", int'(round), m_round);
                checkOutput("cmp_win", int'(win), (m_mode == 4) ? 1 : 0);
                checkOutput("cmp_lose", int'(lose), (m_mode == 5) ? 1 : 0);
            end
        end
    end

    // Directed scenarios.
    initial begin
        logic [NC-1:0] hold;
        int n;

        #1 rst_n = 1'b0;
        applyStimulus(1'b0, '0, 3);
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_led", int'(led), 0);
        checkOutput("reset_round", int'(round), 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1);
        checkOutput("idle_after_reset", int'(state), 0);

        $display("[TB] start with seed 8'h01");
        seed = 8'h01;
        applyStimulus(1'b1, '0, 1);
        for (int i = 0; i < ML; i++) begin
            checkOutput("gen_hold", int'(state), 1);
            applyStimulus(1'b0, '0, 1);
        end
        for (int i = 0; i < SC; i++) begin
            checkOutput("show_state", int'(state), 2);
            checkOutput("show_lamp", int'(led), 4'b0100);
            applyStimulus(1'b0, '0, 1);
        end
        for (int i = 0; i < GC; i++) begin
            checkOutput("show_gap", int'(led), 0);
            applyStimulus(1'b0, '0, 1);
        end
        checkOutput("input_state", int'(state), 3);
        checkOutput("input_round", int'(round), 1);
        for (int i = 0; i < ML; i++) begin
            checkOutput("model_seq", m_seq[i], exp_seq[i]);
        end

        $display("[TB] full winning game");
        for (int r = 1; r <= ML; r++) begin
            waitState(3, 64, "win_wait_input");
            checkOutput("round_step", int'(round), r);
            for (int j = 0; j < r; j++) begin
                applyStimulus(1'b0, presses[j], 1);
                applyStimulus(1'b0, '0, 1);
            end
        end
        checkOutput("win_state", int'(state), 4);
        checkOutput("win_flag", int'(win), 1);

        $display("[TB] held button and multi-press");
        applyStimulus(1'b1, '0, 1);
        checkOutput("restart_gen", int'(state), 1);
        checkOutput("restart_round_kept", int'(round), ML);
        checkOutput("restart_win_clear", int'(win), 0);
        start = 1'b0;
        waitState(2, 16, "held_wait_show");
        hold = NC'(1 << m_seq[0]);
        btn  = hold;
        waitState(3, 32, "held_wait_input");
        applyStimulus(1'b0, hold, 3);
        checkOutput("held_no_advance", int'(state), 3);
        checkOutput("held_round", int'(round), 1);
        applyStimulus(1'b0, '0, 1);
        applyStimulus(1'b0, 4'b0101, 1);
        checkOutput("multi_press_lose", int'(state), 5);
        checkOutput("multi_press_flag", int'(lose), 1);
        applyStimulus(1'b0, '0, 1);

        $display("[TB] timeout");
        applyStimulus(1'b1, '0, 1);
        applyStimulus(1'b0, '0, 1);
        waitState(3, 64, "timeout_wait_input");
        n = 0;
        while (int'(state) == 3 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("timeout_cycles", n, TC);
        checkOutput("timeout_lose", int'(lose), 1);

        $display("[TB] press on the last timeout cycle");
        applyStimulus(1'b1, '0, 1);
        applyStimulus(1'b0, '0, 1);
        waitState(3, 64, "late_wait_input");
        hold = NC'(1 << m_seq[0]);
        repeat (TC - 1) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, hold, 1);
        checkOutput("late_press_state", int'(state), 2);
        checkOutput("late_press_round", int'(round), 2);
        applyStimulus(1'b0, '0, 1);

        $display("[TB] async reset during playback");
        n = 0;
        while (led == '0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("lamp_lit_before_reset", int'(state), 2);
        rst_n = 1'b0;
        #1;
        checkOutput("async_led", int'(led), 0);
        checkOutput("async_state", int'(state), 0);
        checkOutput("async_round", int'(round), 0);
        applyStimulus(1'b0, '0, 2);
        rst_n = 1'b1;
        seed  = 8'h00;
        applyStimulus(1'b1, '0, 1);
        applyStimulus(1'b0, '0, 1);
        waitState(2, 16, "seed0_wait_show");
        checkOutput("seed0_lamp", int'(led), 4'b0100);
        for (int i = 0; i < ML; i++) begin
            checkOutput("seed0_model_seq", m_seq[i], exp_seq[i]);
        end
        waitState(3, 32, "seed0_wait_input");
        applyStimulus(1'b0, 4'b0100, 1);
        checkOutput("seed0_advance_state", int'(state), 2);
        checkOutput("seed0_advance_round", int'(round), 2);
        applyStimulus(1'b0, '0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
